// File: rtl/uart_rx_flow_if.sv
// rtl/uart_rx_flow_if.sv - serial line, flow control, status pulses and byte stream of uart_rx_flow
interface uart_rx_flow_if;
    logic       rxd;
    logic       rtsn;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        input  rxd, out_ready,
        output rtsn, out_valid, out_data, frame_err, overrun, parity_err
    );

    modport slave (
        output rxd, out_ready,
        input  rtsn, out_valid, out_data, frame_err, overrun, parity_err
    );
endinterface

// File: rtl/uart_rx_flow.sv
// rtl/uart_rx_flow.sv - UART receiver with FWFT byte FIFO and RTS flow control
// UART_RX_PARITY_EN selects 8E1 framing with parity_err; otherwise 8N1.
module uart_rx_flow #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int RTS_THRESH = 6
) (
    input  logic           clock,
    input  logic           reset,
    uart_rx_flow_if.master bus
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] THRESH_C  = CW'(RTS_THRESH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

    logic          rx_meta;
    logic          rxs;
    logic [1:0]    sync_fill;
    logic          armed;
    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;
    logic          expire;
    logic          stop_hit;
    logic          push;
    logic          pop;
    logic          do_push;
    logic          full;
    logic          has_data;
    logic          frame_err_q;
    logic          overrun_q;
    logic          rtsn_q;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    // sync_fill keeps the reset value of rxs from arming start detection
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            rx_meta   <= bus.rxd;
            rxs       <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign expire   = (timer == '0);
    assign stop_hit = (state == S_STOP) && expire;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic parity_err_q;
    assign push           = stop_hit && rxs && !par_bad;
    assign bus.parity_err = parity_err_q;
`else
    assign push           = stop_hit && rxs;
    assign bus.parity_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            armed       <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (rxs && sync_fill[1]) begin
                armed <= 1'b1;
            end
            if (!expire) begin
                timer <= timer - 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (!rxs && armed) begin
                        timer <= HALF_LOAD;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (expire) begin
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            timer   <= FULL_LOAD;
                            bit_idx <= '0;
                            state   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (expire) begin
                        shreg <= {rxs, shreg[7:1]};
                        timer <= FULL_LOAD;
                        if (bit_idx == 4'd7) begin
                            state <= S_AFTER_DATA;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (expire) begin
                        par_bad <= ^{shreg, rxs};
                        timer   <= FULL_LOAD;
                        state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // a low stop bit leaves the line low: wait for it to go high before rearming
                    if (expire) begin
                        frame_err_q <= !rxs;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_bad;
`endif
                        if (!rxs) begin
                            armed <= 1'b0;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign has_data = (count != '0);
    assign full     = (count == DEPTH_C);
    assign pop      = has_data && bus.out_ready;
    assign do_push  = push && (!full || pop);

    always_comb begin
        count_next = count;
        if (do_push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !do_push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rtsn_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_next;
            rtsn_q    <= (count_next >= THRESH_C);
            overrun_q <= push && full && !pop;
        end
    end

    assign bus.out_valid = has_data;
    assign bus.out_data  = has_data ? mem[rd_ptr] : 8'h00;
    assign bus.rtsn      = rtsn_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_flow.sv
// tb/tb_uart_rx_flow.sv - table, hand-sequence and randomized checks for uart_rx_flow
module tb_uart_rx_flow;
    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int RTS_THRESH = 6;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic pcie_sys_clk_p = 1'b0;
    logic reset = 1'b1;

    uart_rx_flow_if u_if ();

    uart_rx_flow #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RTS_THRESH (RTS_THRESH)
    ) dut (
        .clock (pcie_sys_clk_p),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 pcie_sys_clk_p = ~pcie_sys_clk_p;

    logic [7:0] got[$];
    int n_vcyc = 0, n_fe = 0, n_ov = 0, n_pe = 0;

    always @(negedge pcie_sys_clk_p) begin
        if (!reset) begin
            if (u_if.out_valid && u_if.out_ready) got.push_back(u_if.out_data);
            if (u_if.out_valid)  n_vcyc++;
            if (u_if.frame_err)  n_fe++;
            if (u_if.overrun)    n_ov++;
            if (u_if.parity_err) n_pe++;
        end
    end

    int n_checks = 0, n_pass = 0;
    int b_got, b_vc, b_fe, b_ov, b_pe;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [7:0] data;
        bit         stop_bit;
        int         exp_n;
        int         exp_fe;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic check_got(input string name, input int idx, input int exp);
        if (idx < got.size()) check(name, int'(got[idx]), exp);
        else check(name, -1, exp);
    endtask

    task automatic mark();
        b_got = got.size();
        b_vc  = n_vcyc;
        b_fe  = n_fe;
        b_ov  = n_ov;
        b_pe  = n_pe;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pcie_sys_clk_p);
            #1;
            if (rand_ready) u_if.out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drive_bit(input bit b);
        u_if.rxd = b;
        step(CLK_DIV);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR) drive_bit((^d) ^ ~par_ok);
        drive_bit(stop_bit);
        u_if.rxd = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rtsn"},       int'(u_if.rtsn), 0);
        check({tag, "_out_valid"},  int'(u_if.out_valid), 0);
        check({tag, "_out_data"},   int'(u_if.out_data), 0);
        check({tag, "_frame_err"},  int'(u_if.frame_err), 0);
        check({tag, "_overrun"},    int'(u_if.overrun), 0);
        check({tag, "_parity_err"}, int'(u_if.parity_err), 0);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int n_bad;
        int occ;

        vecs[0] = '{8'h55, 1'b1, 1, 0};
        vecs[1] = '{8'hA3, 1'b1, 1, 0};
        vecs[2] = '{8'h3C, 1'b0, 0, 1};
        vecs[3] = '{8'h3C, 1'b1, 1, 0};
        vecs[4] = '{8'h00, 1'b1, 1, 0};
        vecs[5] = '{8'hFF, 1'b1, 1, 0};
        vecs[6] = '{8'h80, 1'b0, 0, 1};
        vecs[7] = '{8'h7E, 1'b1, 1, 0};

        u_if.rxd       = 1'b1;
        u_if.out_ready = 1'b1;
        reset          = 1'b1;
        step(5);
        check_reset_vals("reset");
        reset = 1'b0;
        step(5);

        // back-to-back frames
        mark();
        send_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'hA3, 1'b1, 1'b1);
        step(4);
        check("b2b_count", got.size() - b_got, 2);
        check_got("b2b_data0", b_got, 8'h55);
        check_got("b2b_data1", b_got + 1, 8'hA3);
        check("b2b_valid_cycles", n_vcyc - b_vc, 2);
        check("b2b_frame_err", n_fe - b_fe, 0);
        check("b2b_parity_err", n_pe - b_pe, 0);

        for (int i = 0; i < 8; i++) begin
            mark();
            send_frame(vecs[i].data, vecs[i].stop_bit, 1'b1);
            step(4);
            check($sformatf("vec%0d_count", i), got.size() - b_got, vecs[i].exp_n);
            if (vecs[i].exp_n == 1) check_got($sformatf("vec%0d_data", i), b_got, int'(vecs[i].data));
            check($sformatf("vec%0d_frame_err", i), n_fe - b_fe, vecs[i].exp_fe);
            check($sformatf("vec%0d_overrun", i), n_ov - b_ov, 0);
        end

        // glitch shorter than half a bit
        mark();
        u_if.rxd = 1'b0;
        step(4);
        u_if.rxd = 1'b1;
        step(30);
        check("glitch_count", got.size() - b_got, 0);
        check("glitch_frame_err", n_fe - b_fe, 0);
        send_frame(8'h7E, 1'b1, 1'b1);
        step(4);
        check("glitch_next_count", got.size() - b_got, 1);
        check_got("glitch_next_data", b_got, 8'h7E);

        // flow control with a stalled consumer
        u_if.out_ready = 1'b0;
        mark();
        for (int k = 1; k <= 9; k++) begin
            send_frame(8'(k), 1'b1, 1'b1);
            step(2);
            occ = (k < FIFO_DEPTH) ? k : FIFO_DEPTH;
            check($sformatf("flow_rtsn_after_%0d", k), int'(u_if.rtsn), int'(occ >= RTS_THRESH));
            check($sformatf("flow_overrun_after_%0d", k), n_ov - b_ov, k - occ);
        end
        u_if.out_ready = 1'b1;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
            @(negedge pcie_sys_clk_p);
            check($sformatf("drain_valid_%0d", j), int'(u_if.out_valid), 1);
            check($sformatf("drain_rtsn_%0d", j), int'(u_if.rtsn), int'((FIFO_DEPTH - j) >= RTS_THRESH));
        end
        step(3);
        check("drain_count", got.size() - b_got, FIFO_DEPTH);
        for (int j = 0; j < FIFO_DEPTH; j++) check_got($sformatf("drain_data_%0d", j), b_got + j, j + 1);
        check("drain_empty", int'(u_if.out_valid), 0);
        check("drain_rtsn_low", int'(u_if.rtsn), 0);

        // reset during data bit 4 of 0xF0 with a byte already buffered
        u_if.out_ready = 1'b0;
        mark();
        send_frame(8'h11, 1'b1, 1'b1);
        step(2);
        check("pre_reset_valid", int'(u_if.out_valid), 1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        u_if.rxd = 1'b1;
        step(CLK_DIV / 2);
        reset = 1'b1;
        step(2);
        check_reset_vals("midframe");
        reset = 1'b0;
        step(20);
        check("post_reset_empty", int'(u_if.out_valid), 0);
        u_if.out_ready = 1'b1;
        send_frame(8'h0F, 1'b1, 1'b1);
        step(4);
        check("post_reset_count", got.size() - b_got, 1);
        check_got("post_reset_data", b_got, 8'h0F);

        // line held low across reset release is not a start bit
        reset = 1'b1;
        u_if.rxd = 1'b0;
        step(3);
        mark();
        reset = 1'b0;
        step(40);
        u_if.rxd = 1'b1;
        step(200);
        check("low_release_count", got.size() - b_got, 0);
        check("low_release_valid_cycles", n_vcyc - b_vc, 0);
        check("low_release_frame_err", n_fe - b_fe, 0);

`ifdef UART_RX_PARITY_EN
        mark();
        send_frame(8'h07, 1'b1, 1'b0);
        step(4);
        check("par_bad_pulse", n_pe - b_pe, 1);
        check("par_bad_count", got.size() - b_got, 0);
        send_frame(8'h07, 1'b1, 1'b1);
        step(4);
        check("par_good_count", got.size() - b_got, 1);
        check_got("par_good_data", b_got, 8'h07);
        check("par_good_pulse", n_pe - b_pe, 1);
`endif

        // randomized frames against a queue model, random consumer stalls
        mark();
        n_bad = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            bit st;
            d  = 8'($urandom);
            st = ($urandom_range(0, 4) != 0);
            send_frame(d, st, 1'b1);
            if (st) exp_q.push_back(d);
            else n_bad++;
            step($urandom_range(1, 6));
        end
        rand_ready = 1'b0;
        u_if.out_ready = 1'b1;
        step(12);
        check("rand_count", got.size() - b_got, exp_q.size());
        foreach (exp_q[i]) check_got($sformatf("rand_data_%0d", i), b_got + i, int'(exp_q[i]));
        check("rand_frame_err", n_fe - b_fe, n_bad);
        check("rand_overrun", n_ov - b_ov, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
